// File: rtl/rf_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_fifo_pkg
// Purpose  : Shared defaults, types and constants for the register-file FIFO
//            controller (rf_fifo_ctrl, rf_ptr_ctr).
// Revision : 1.0 - initial release
// ============================================================================
package rf_fifo_pkg;

  // Default geometry: 2**DEF_SEL entries of DEF_DATA_WIDTH bits
  localparam int DEF_SEL        = 2;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEPTH          = 2 ** DEF_SEL;

  // Pointer into the register file and occupancy counter (0..DEPTH)
  typedef logic [DEF_SEL-1:0] ptr_t;
  typedef logic [DEF_SEL:0]   cnt_t;

endpackage : rf_fifo_pkg
`default_nettype wire

// File: rtl/rf_ptr_ctr.sv
`default_nettype none
// ============================================================================
// Module   : rf_ptr_ctr
// Purpose  : SEL-bit pointer counter that wraps modulo 2**SEL, with increment
//            enable and asynchronous active-high reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rf_ptr_ctr
  import rf_fifo_pkg::*;
#(
  parameter int SEL = DEF_SEL
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  output logic [SEL-1:0] ptr
);

  // Advance by one on each enabled edge; natural binary overflow gives the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + SEL'(1);
    end
  end

endmodule : rf_ptr_ctr
`default_nettype wire

// File: rtl/rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_fifo_ctrl
// Purpose  : Pointer/flag controller turning a 2**SEL-entry register file
//            with registered read data into a FIFO. Drives the file's write
//            port and read address, tracks occupancy, and flags the cycle in
//            which the file's read output holds the popped word.
// Options  : RF_FIFO_ERR_EN - adds sticky err_overflow / err_underflow ports.
// Revision : 1.0 - initial release
// ============================================================================
module rf_fifo_ctrl
  import rf_fifo_pkg::*;
#(
  parameter int SEL        = DEF_SEL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // push port
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  // pop port
  output logic                  pop_valid,
  input  logic                  pop_ready,
  // register-file side
  output logic                  wr_en,
  output logic [SEL-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [SEL-1:0]        rd_addr,
  output logic                  rd_data_valid,
  // status
  output logic [SEL:0]          count,
  output logic                  full,
`ifdef RF_FIFO_ERR_EN
  output logic                  empty,
  output logic                  err_overflow,
  output logic                  err_underflow
`else
  output logic                  empty
`endif
);

  typedef logic [SEL:0] occ_t;
  localparam occ_t DEPTH_OCC = occ_t'(2 ** SEL);

  logic push_acc;
  logic pop_acc;
  logic [SEL-1:0] wptr;
  logic [SEL-1:0] rptr;

  // Flags come only from the occupancy register, never from pointer equality,
  // so handshake readiness never depends on push_valid / pop_ready.
  assign full       = (count == DEPTH_OCC);
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;

  // Reset masks the write strobe so the file is never written during reset
  assign push_acc = push_valid && push_ready && !rst;
  assign pop_acc  = pop_valid && pop_ready;

  // Write path is purely combinational; the file captures on the wptr edge
  assign wr_en   = push_acc;
  assign wr_addr = wptr;
  assign wr_data = push_data;
  assign rd_addr = rptr;

  rf_ptr_ctr #(.SEL(SEL)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (push_acc),
    .ptr (wptr)
  );

  rf_ptr_ctr #(.SEL(SEL)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_acc),
    .ptr (rptr)
  );

  // Occupancy: simultaneous push and pop cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + occ_t'(1);
        2'b01:   count <= count - occ_t'(1);
        default: count <= count;
      endcase
    end
  end

  // The file's read data is registered, so the popped word appears one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= pop_acc;
    end
  end

`ifdef RF_FIFO_ERR_EN
  // Sticky protocol-violation flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_valid && full) err_overflow  <= 1'b1;
      if (pop_ready && empty) err_underflow <= 1'b1;
    end
  end
`endif

endmodule : rf_fifo_ctrl
`default_nettype wire

// File: tb/tb_rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_fifo_ctrl
// Purpose  : Directed self-checking bench for rf_fifo_ctrl, including a small
//            behavioural register file with registered read data.
// Options  : RF_FIFO_ERR_EN - also checks the sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_addr;
  logic        rd_data_valid;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef RF_FIFO_ERR_EN
  logic        err_overflow;
  logic        err_underflow;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_fifo_ctrl #(.SEL(2), .DATA_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_data     (push_data),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .count         (count),
    .full          (full),
`ifdef RF_FIFO_ERR_EN
    .empty         (empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`else
    .empty         (empty)
`endif
  );

  // Behavioural register file: write on edge, registered read of rd_addr
  logic [15:0] mem [4];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    push_valid = 1'b1;
    push_data  = 16'hDEAD;
    pop_ready  = 1'b1;
    tick();
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({empty, full, push_ready, pop_valid} !== 4'b1010) begin failures++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, push_ready, pop_valid}); end
    checks++; if ({wr_en, rd_data_valid} !== 2'b00) begin failures++; $display("FAIL reset_wren_rdv got=%b exp=00", {wr_en, rd_data_valid}); end
    checks++; if ({wr_addr, rd_addr} !== 4'b0000) begin failures++; $display("FAIL reset_addr got=%b exp=0000", {wr_addr, rd_addr}); end
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 16'h1111 * 16'(i + 1);
      push_valid = 1'b1;
      push_data  = d;
      #1;
      checks++; if ({wr_en, push_ready} !== 2'b11) begin failures++; $display("FAIL fill_wren[%0d] got=%b exp=11", i, {wr_en, push_ready}); end
      checks++; if (wr_addr !== 2'(i) || wr_data !== d) begin failures++; $display("FAIL fill_addr[%0d] got=%0d/%h exp=%0d/%h", i, wr_addr, wr_data, i, d); end
      tick();
    end
    push_data = 16'h5555;
    #1;
    checks++; if (count !== 3'd4 || full !== 1'b1 || push_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%0d/%b/%b exp=4/1/0", count, full, push_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL fill_5th_wren got=%b exp=0", wr_en); end
    tick();
    push_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4 || wr_addr !== 2'd0) begin failures++; $display("FAIL fill_5th_ignored got=%0d/%0d exp=4/0", count, wr_addr); end
`ifdef RF_FIFO_ERR_EN
    checks++; if (err_overflow !== 1'b1 || err_underflow !== 1'b0) begin failures++; $display("FAIL fill_err got=%b%b exp=10", err_overflow, err_underflow); end
`endif
  endtask

  task automatic test_drain();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 16'h1111 * 16'(i + 1);
      pop_ready = 1'b1;
      #1;
      checks++; if (pop_valid !== 1'b1 || rd_addr !== 2'(i)) begin failures++; $display("FAIL drain_head[%0d] got=%b/%0d exp=1/%0d", i, pop_valid, rd_addr, i); end
      tick();
      checks++; if (rd_data_valid !== 1'b1 || rd_q !== d) begin failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rd_data_valid, rd_q, d); end
    end
    pop_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || count !== 3'd0 || pop_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b/%0d/%b exp=1/0/0", empty, count, pop_valid); end
    tick();
    checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("FAIL drain_rdv_clear got=%b exp=0", rd_data_valid); end
  endtask

  // Pointers start at 0: first burst lands on 0,1,2, second on 3,0,1
  task automatic test_wrap();
    logic [1:0] exp_addr;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        exp_addr   = 2'(3 * b + i);
        push_valid = 1'b1;
        push_data  = 16'hA000 + 16'(3 * b + i);
        #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== exp_addr) begin failures++; $display("FAIL wrap_waddr[%0d] got=%b/%0d exp=1/%0d", 3 * b + i, wr_en, wr_addr, exp_addr); end
        tick();
      end
      push_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_addr  = 2'(3 * b + i);
        pop_ready = 1'b1;
        #1;
        checks++; if (rd_addr !== exp_addr) begin failures++; $display("FAIL wrap_raddr[%0d] got=%0d exp=%0d", 3 * b + i, rd_addr, exp_addr); end
        tick();
        checks++; if (rd_data_valid !== 1'b1 || rd_q !== 16'hA000 + 16'(3 * b + i)) begin failures++; $display("FAIL wrap_data[%0d] got=%b/%h exp=1/%h", 3 * b + i, rd_data_valid, rd_q, 16'hA000 + 16'(3 * b + i)); end
      end
      pop_ready = 1'b0;
    end
    #1;
    checks++; if (empty !== 1'b1 || wr_addr !== 2'd2 || rd_addr !== 2'd2) begin failures++; $display("FAIL wrap_end got=%b/%0d/%0d exp=1/2/2", empty, wr_addr, rd_addr); end
  endtask

  // Pointers at 2/2: preload two, then 10 cycles of push+pop at count 2
  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1;
      push_data  = 16'hB000 + 16'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      push_valid = 1'b1;
      push_data  = 16'hB000 + 16'(k + 2);
      pop_ready  = 1'b1;
      #1;
      checks++; if (count !== 3'd2 || wr_en !== 1'b1 || pop_valid !== 1'b1) begin failures++; $display("FAIL b2b_state[%0d] got=%0d/%b/%b exp=2/1/1", k, count, wr_en, pop_valid); end
      checks++; if (wr_addr !== 2'(k) || rd_addr !== 2'(k + 2)) begin failures++; $display("FAIL b2b_ptrs[%0d] got=%0d/%0d exp=%0d/%0d", k, wr_addr, rd_addr, k % 4, (k + 2) % 4); end
      tick();
      checks++; if (rd_data_valid !== 1'b1 || rd_q !== 16'hB000 + 16'(k)) begin failures++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", k, rd_data_valid, rd_q, 16'hB000 + 16'(k)); end
    end
    push_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rd_q !== 16'hB000 + 16'(10 + i)) begin failures++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, rd_q, 16'hB000 + 16'(10 + i)); end
    end
    pop_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || wr_addr !== 2'd2 || rd_addr !== 2'd2) begin failures++; $display("FAIL b2b_end got=%b/%0d/%0d exp=1/2/2", empty, wr_addr, rd_addr); end
  endtask

  task automatic test_push_empty();
`ifdef RF_FIFO_ERR_EN
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL pe_no_underflow got=%b exp=0", err_underflow); end
`endif
    push_valid = 1'b1;
    push_data  = 16'hC0DE;
    pop_ready  = 1'b1;
    #1;
    checks++; if (pop_valid !== 1'b0 || wr_en !== 1'b1) begin failures++; $display("FAIL pe_same_cycle got=%b/%b exp=0/1", pop_valid, wr_en); end
    tick();
    push_valid = 1'b0;
    #1;
    checks++; if (pop_valid !== 1'b1 || count !== 3'd1 || rd_data_valid !== 1'b0) begin failures++; $display("FAIL pe_next_cycle got=%b/%0d/%b exp=1/1/0", pop_valid, count, rd_data_valid); end
`ifdef RF_FIFO_ERR_EN
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL pe_underflow got=%b exp=1", err_underflow); end
`endif
    tick();
    pop_ready = 1'b0;
    checks++; if (rd_data_valid !== 1'b1 || rd_q !== 16'hC0DE || count !== 3'd0) begin failures++; $display("FAIL pe_pop got=%b/%h/%0d exp=1/c0de/0", rd_data_valid, rd_q, count); end
  endtask

  // Pointers at 3/3: push three, then one push+pop so rd_data_valid is high
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_data  = 16'hD000 + 16'(i);
      tick();
    end
    pop_ready = 1'b1;
    push_data = 16'hD003;
    tick();
    checks++; if (count !== 3'd3 || rd_data_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=3/1", count, rd_data_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || {empty, full, push_ready, pop_valid} !== 4'b1010) begin failures++; $display("FAIL ar_flags got=%0d/%b exp=0/1010", count, {empty, full, push_ready, pop_valid}); end
    checks++; if ({wr_en, rd_data_valid} !== 2'b00 || wr_addr !== 2'd0 || rd_addr !== 2'd0) begin failures++; $display("FAIL ar_outs got=%b/%0d/%0d exp=00/0/0", {wr_en, rd_data_valid}, wr_addr, rd_addr); end
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    tick();
    rst = 1'b0;
    push_valid = 1'b1;
    push_data  = 16'hE000;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd0) begin failures++; $display("FAIL ar_first_push got=%b/%0d exp=1/0", wr_en, wr_addr); end
    tick();
    push_valid = 1'b0;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL ar_count got=%0d exp=1", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_push_empty();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule : tb_rf_fifo_ctrl
`default_nettype wire
